uart_tx_sched: RTL and testbench

- Transmit-side scheduler for the on-board UART transmitter (async_transmitter-style: 1-cycle start pulse, data bus, busy flag).
- Arbitrates two byte producers (port 0: CPU conf-space write path; port 1: debug/monitor source) round-robin into a shared TX FIFO.
- Sequences the transmitter one byte at a time, honouring busy, so no write is lost while a frame is on the wire.

---
 rtl/uart_tx_sched.sv | 137 +++++++++++++
 tb/tb_uart_tx_sched.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Round-robin two-port byte scheduler feeding a shared TX FIFO,
// sequencing a start/busy style UART transmitter one byte at a time.
module uart_tx_sched #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int GUARD = 2
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          req0_valid,
    input  logic [7:0]    req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [7:0]    req1_data,
    output logic          req1_ready,
    input  logic          flush,
    input  logic          tx_busy,
    output logic          tx_start,
    output logic [7:0]    tx_data,
    output logic [AW:0]   fifo_count,
    output logic          fifo_empty,
    output logic          fifo_full
);

    localparam int CW = (GUARD > 1) ? $clog2(GUARD) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          start_q, start_d;
    logic [7:0]    data_q, data_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic          last_q, last_d;
    logic [7:0]    mem_q [DEPTH];

    logic          grant0, grant1;
    logic          push0, push1, push, pop;
    logic [7:0]    wdata;

    assign fifo_full  = (count_q == (AW+1)'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign fifo_count = count_q;
    assign tx_start   = start_q;
    assign tx_data    = data_q;

    // last_q high means port 1 won the previous transfer
    assign grant0 = req0_valid & (~req1_valid | last_q);
    assign grant1 = req1_valid & (~req0_valid | ~last_q);

    assign req0_ready = grant0 & ~fifo_full & ~flush;
    assign req1_ready = grant1 & ~fifo_full & ~flush;

    assign push0 = req0_valid & req0_ready;
    assign push1 = req1_valid & req1_ready;
    assign push  = push0 | push1;
    assign wdata = push1 ? req1_data : req0_data;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty && !tx_busy) begin
                    pop     = 1'b1;
                    start_d = 1'b1;
                    cnt_d   = CW'(GUARD - 1);
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DRAIN: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // flush only empties the queue; a byte already launched runs to completion
    always_comb begin
        data_d   = pop ? mem_q[rd_ptr_q] : data_q;
        last_d   = push ? push1 : last_q;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            start_q  <= 1'b0;
            data_q   <= '0;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            last_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            start_q  <= start_d;
            data_q   <= data_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            last_q   <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomized bench for uart_tx_sched against a queue-based scheduler model
// and a simple busy-window transmitter stand-in.
module tb_uart_tx_sched;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int GUARD = 2;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          req0_valid = 1'b0;
    logic [7:0]    req0_data = '0;
    logic          req0_ready;
    logic          req1_valid = 1'b0;
    logic [7:0]    req1_data = '0;
    logic          req1_ready;
    logic          flush = 1'b0;
    logic          tx_busy = 1'b0;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic [AW:0]   fifo_count;
    logic          fifo_empty;
    logic          fifo_full;

    uart_tx_sched #(.DEPTH(DEPTH), .AW(AW), .GUARD(GUARD)) dut (
        .clk(clk),
        .resetn(resetn),
        .req0_valid(req0_valid),
        .req0_data(req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_data(req1_data),
        .req1_ready(req1_ready),
        .flush(flush),
        .tx_busy(tx_busy),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .fifo_count(fifo_count),
        .fifo_empty(fifo_empty),
        .fifo_full(fifo_full)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    // reference model: queue of accepted bytes plus launch-pacing state
    logic [7:0] q[$];
    bit         lg = 1'b1;
    bit         freed = 1'b1;
    int         since = 1000;
    logic [7:0] lb = '0;
    int         launches = 0;

    // environment
    int         cyc = 0;
    int         cs = 0;
    int         cur_blen = 0;
    bit         have_start = 1'b0;
    bit         stall = 1'b0;
    int         blen = 0;
    int         rate0 = 0;
    int         rate1 = 0;
    int         flush_rate = 0;
    bit         force_flush = 1'b0;
    logic [7:0] src0[$];
    logic [7:0] src1[$];

    task automatic tick();
        bit g0, g1, r0m, r1m, full_m, launch, fset, acc0, acc1;
        @(negedge clk);
        if (!req0_valid) begin
            if (src0.size() != 0) begin
                req0_valid = 1'b1;
                req0_data  = src0.pop_front();
            end else if ($urandom_range(0, 99) < rate0) begin
                req0_valid = 1'b1;
                req0_data  = 8'($urandom);
            end
        end
        if (!req1_valid) begin
            if (src1.size() != 0) begin
                req1_valid = 1'b1;
                req1_data  = src1.pop_front();
            end else if ($urandom_range(0, 99) < rate1) begin
                req1_valid = 1'b1;
                req1_data  = 8'($urandom);
            end
        end
        flush   = force_flush || ($urandom_range(0, 99) < flush_rate);
        tx_busy = stall || (have_start && cyc >= cs + GUARD - 1 &&
                            cyc < cs + GUARD - 1 + cur_blen);
        #1;
        full_m = (q.size() == DEPTH);
        g0     = req0_valid && (!req1_valid || lg);
        g1     = req1_valid && (!req0_valid || !lg);
        r0m    = g0 && !full_m && !flush;
        r1m    = g1 && !full_m && !flush;
        launch = freed && q.size() != 0 && !tx_busy;
        fset   = !freed && since > GUARD && !tx_busy;
        chk("ready0", req0_ready, r0m);
        chk("ready1", req1_ready, r1m);
        chk("count", fifo_count, q.size());
        chk("empty", fifo_empty, q.size() == 0);
        chk("full", fifo_full, full_m);
        acc0 = req0_valid && req0_ready;
        acc1 = req1_valid && req1_ready;
        @(posedge clk);
        cyc++;
        #1;
        if (launch) begin
            lb = q.pop_front();
            freed = 1'b0;
            since = 0;
            launches++;
        end
        if (r0m) begin
            q.push_back(req0_data);
            lg = 1'b0;
        end else if (r1m) begin
            q.push_back(req1_data);
            lg = 1'b1;
        end
        if (flush) q.delete();
        if (fset) freed = 1'b1;
        if (since < 1000) since++;
        chk("tx_start", tx_start, launch);
        chk("tx_data", tx_data, lb);
        if (tx_start) begin
            have_start = 1'b1;
            cs = cyc;
            cur_blen = (blen < 0) ? int'($urandom_range(0, 25)) : blen;
        end
        if (acc0) req0_valid = 1'b0;
        if (acc1) req1_valid = 1'b0;
    endtask

    task automatic wait_launch(input string tag);
        int start_cnt;
        bit seen;
        start_cnt = launches;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            seen = (launches != start_cnt);
        end
        chk(tag, seen, 1'b1);
    endtask

    task automatic mid_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        flush = 1'b0;
        #2 resetn = 1'b0;
        #1;
        chk("rst_start", tx_start, 1'b0);
        chk("rst_count", fifo_count, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_empty", fifo_empty, 1'b1);
        q.delete();
        lg = 1'b1;
        freed = 1'b1;
        since = 1000;
        lb = '0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        int saved;
        #12;
        chk("init_start", tx_start, 1'b0);
        chk("init_data", tx_data, 0);
        chk("init_count", fifo_count, 0);
        chk("init_empty", fifo_empty, 1'b1);
        chk("init_full", fifo_full, 1'b0);
        @(negedge clk);
        resetn = 1'b1;

        // single byte, idle transmitter
        src0.push_back(8'h41);
        repeat (8) tick();

        // both ports contending
        src0.push_back(8'hA0); src0.push_back(8'hA1);
        src1.push_back(8'hB0); src1.push_back(8'hB1);
        repeat (30) tick();

        // 20-cycle busy frames
        blen = 20;
        src0.push_back(8'h01); src0.push_back(8'h02); src0.push_back(8'h03);
        repeat (100) tick();

        // fill while stalled, then drain with wrap
        stall = 1'b1;
        rate0 = 100;
        rate1 = 100;
        repeat (40) tick();
        stall = 1'b0;
        blen = 3;
        rate0 = 60;
        rate1 = 60;
        saved = launches;
        repeat (400) tick();
        chk("wrap_launches", launches - saved >= 40, 1'b1);
        rate0 = 0;
        rate1 = 0;
        repeat (60) tick();

        // flush with bytes queued and one in flight
        stall = 1'b1;
        blen = 20;
        for (int i = 0; i < 7; i++) src0.push_back(8'(8'h60 + i));
        repeat (10) tick();
        stall = 1'b0;
        wait_launch("flush_wait");
        force_flush = 1'b1;
        tick();
        force_flush = 1'b0;
        chk("flush_count", fifo_count, 0);
        saved = launches;
        repeat (60) tick();
        chk("flush_nolaunch", launches, saved);

        // random mix
        blen = -1;
        rate0 = 40;
        rate1 = 40;
        flush_rate = 2;
        repeat (2000) tick();
        rate0 = 0;
        rate1 = 0;
        flush_rate = 0;
        repeat (80) tick();

        // reset while in SETTLE, then a tie
        blen = 0;
        src0.push_back(8'h5A);
        wait_launch("rst_wait");
        mid_reset();
        src0.push_back(8'h11);
        src1.push_back(8'h22);
        repeat (20) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
